// File: rtl/scan_seq_ctrl.sv
// Mux-scan chain sequencer: loads stimulus, captures, and unloads the response while the next stimulus loads; compares each response against its expected value.
// Latency: a handshake at cycle t gives CHAIN_LEN shift cycles, then capture at t+CHAIN_LEN+1. The last pattern adds CHAIN_LEN unload cycles, then done.
// Backpressure: pat_ready is high only while waiting for a pattern. The chain clock is gated off while the source stalls, so a captured response survives any gap.
module scan_seq_ctrl #(
  parameter int CHAIN_LEN = 2,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 pat_valid,
  output logic                 pat_ready,
  input  logic [CHAIN_LEN-1:0] pat_in,
  input  logic [CHAIN_LEN-1:0] pat_exp,
  input  logic                 pat_last,
  output logic                 scan_en,
  output logic                 scan_in,
  input  logic                 scan_out,
  output logic                 chain_ce,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [CNT_W-1:0]     pat_cnt,
  output logic [CNT_W-1:0]     fail_cnt
);

  // One spare bit in the shift counter keeps CHAIN_LEN=1 legal (one shift cycle).
  localparam int              SC_W    = $clog2(CHAIN_LEN) + 1;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SHIFT,
    S_CAPTURE,
    S_UNLOAD,
    S_DONE
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [SC_W-1:0]      sh_cnt_q;
  logic [CHAIN_LEN-1:0] stim_q;     // stimulus being shifted in, MSB leaves first
  logic [CHAIN_LEN-1:0] exp_q;      // expected response currently in the chain
  logic [CHAIN_LEN-1:0] exp_nxt_q;  // expectation for the pattern being loaded
  logic                 last_q;
  logic                 has_resp_q; // chain holds a captured response worth checking

  logic shifting;
  logic sh_term;
  logic accept;
  logic start_ok;
  logic cap_ok;
  logic mismatch;

  assign shifting = (state_q == S_SHIFT) || (state_q == S_UNLOAD);
  assign sh_term  = (sh_cnt_q == SC_LAST);
  // An abort in a busy state wins over everything else on that edge.
  assign accept   = (state_q == S_WAIT) && pat_valid && !abort;
  assign start_ok = (state_q == S_IDLE) && start;
  assign cap_ok   = (state_q == S_CAPTURE) && !abort;
  // exp_q shifts in step with the chain, so its MSB always lines up with scan_out.
  assign mismatch = shifting && has_resp_q && !abort && (scan_out != exp_q[CHAIN_LEN-1]);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore output decode; no input reaches an output combinationally.
  always_comb begin
    state_d   = state_q;
    scan_en   = 1'b0;
    scan_in   = 1'b0;
    chain_ce  = 1'b1;
    pat_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = S_WAIT;
      end
      S_WAIT: begin
        // Chain frozen so a captured response survives an arbitrary stall.
        chain_ce  = 1'b0;
        pat_ready = 1'b1;
        if (pat_valid) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        scan_en = 1'b1;
        scan_in = stim_q[CHAIN_LEN-1];
        if (sh_term) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        state_d = last_q ? S_UNLOAD : S_WAIT;
      end
      S_UNLOAD: begin
        scan_en = 1'b1;
        if (sh_term) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if ((state_q != S_IDLE) && abort) state_d = S_IDLE;
  end

  // Shift counter: counts 0..CHAIN_LEN-1 inside each shift/unload burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_cnt_q <= '0;
    end else if (shifting && !abort && !sh_term) begin
      sh_cnt_q <= sh_cnt_q + 1'b1;
    end else begin
      sh_cnt_q <= '0;
    end
  end

  // Pattern registers: latch on handshake, stimulus shifts out MSB first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stim_q    <= '0;
      exp_nxt_q <= '0;
      last_q    <= 1'b0;
    end else if (accept) begin
      stim_q    <= pat_in;
      exp_nxt_q <= pat_exp;
      last_q    <= pat_last;
    end else if (state_q == S_SHIFT) begin
      stim_q    <= stim_q << 1;
    end
  end

  // Expected-response register: armed at capture, walked along with the unload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q      <= '0;
      has_resp_q <= 1'b0;
    end else if (start_ok) begin
      has_resp_q <= 1'b0;
    end else if (cap_ok) begin
      exp_q      <= exp_nxt_q;
      has_resp_q <= 1'b1;
    end else if (shifting) begin
      exp_q      <= exp_q << 1;
    end
  end

  // Session results: sticky fail plus saturating pattern and bit-mismatch counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail     <= 1'b0;
      pat_cnt  <= '0;
      fail_cnt <= '0;
    end else if (start_ok) begin
      fail     <= 1'b0;
      pat_cnt  <= '0;
      fail_cnt <= '0;
    end else begin
      if (cap_ok && (pat_cnt != {CNT_W{1'b1}})) begin
        pat_cnt <= pat_cnt + 1'b1;
      end
      if (mismatch) begin
        fail <= 1'b1;
        if (fail_cnt != {CNT_W{1'b1}}) fail_cnt <= fail_cnt + 1'b1;
      end
    end
  end

endmodule
